// File: rtl/ppu_reg_file_if.sv
// CPU-side register bus between the WRAM decoder and the PPU register file.
interface ppu_reg_file_if;
  logic       ppu_reg_cs;
  logic [2:0] ppu_reg_addr;
  logic       WE;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;

  modport master (
    output ppu_reg_cs, ppu_reg_addr, WE, data_in,
    input  data_out, busy
  );

  modport slave (
    input  ppu_reg_cs, ppu_reg_addr, WE, data_in,
    output data_out, busy
  );
endinterface

// File: rtl/ppu_reg_file.sv
// PPU register file for $2000-$2007: control/mask/status, scroll, OAM and VRAM ports, NMI.
// Optional feature: define PPU_OPEN_BUS_EN to add the open-bus data latch.
module ppu_reg_file #(
  parameter int unsigned VADDR_W = 14,
  parameter int unsigned OAM_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  ppu_reg_file_if.slave      bus,
  output logic [VADDR_W-1:0] vram_addr,
  input  logic [7:0]         vram_data_in,
  output logic [7:0]         vram_data_out,
  output logic               vram_WE,
  output logic [OAM_W-1:0]   oam_addr,
  input  logic [7:0]         oam_data_in,
  output logic [7:0]         oam_data_out,
  output logic               oam_WE,
  input  logic               vblank_start,
  input  logic               vblank_end,
  input  logic               sprite0_hit,
  input  logic               sprite_ovf,
  output logic [7:0]         ctrl,
  output logic [7:0]         mask,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic               nmi
);

  localparam int unsigned T_W = 14;

  typedef enum logic [1:0] {IDLE, RD_FETCH, WR_STROBE} state_t;

  state_t             state;
  logic               w;
  logic [T_W-1:0]     t;
  logic [VADDR_W-1:0] v;
  logic [7:0]         buffer;
  logic               vblank_flag;
  logic               vram_we_q;
  logic               oam_we_q;

  logic               acc;
  logic               wr;
  logic               rd;
  logic [VADDR_W-1:0] inc;
  logic               flag_next;
  logic [7:0]         rd_data;

  // Accesses arriving while a PPUDATA transaction is pending are ignored.
  assign acc = bus.ppu_reg_cs && (state == IDLE);
  assign wr  = acc && bus.WE;
  assign rd  = acc && !bus.WE;
  assign inc = ctrl[2] ? VADDR_W'(32) : VADDR_W'(1);

  assign vram_addr = v;
  // Strobes are gated by reset so a pending write never lands during reset.
  assign vram_WE   = vram_we_q & ~reset;
  assign oam_WE    = oam_we_q & ~reset;

  // vblank_end dominates, then vblank_start beats the clear-on-read.
  always_comb begin
    flag_next = vblank_flag;
    if (vblank_end)
      flag_next = 1'b0;
    else if (vblank_start)
      flag_next = 1'b1;
    else if (rd && (bus.ppu_reg_addr == 3'd2))
      flag_next = 1'b0;
  end

`ifdef PPU_OPEN_BUS_EN
  logic [7:0] bus_latch;

  always_comb begin
    rd_data = bus_latch;
    case (bus.ppu_reg_addr)
      3'd2:    rd_data = {vblank_flag, sprite0_hit, sprite_ovf, bus_latch[4:0]};
      3'd4:    rd_data = oam_data_in;
      3'd7:    rd_data = buffer;
      default: rd_data = bus_latch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus_latch <= 8'h00;
    else if (wr)
      bus_latch <= bus.data_in;
    else if (rd)
      bus_latch <= rd_data;
  end
`else
  always_comb begin
    rd_data = 8'h00;
    case (bus.ppu_reg_addr)
      3'd2:    rd_data = {vblank_flag, sprite0_hit, sprite_ovf, 5'b00000};
      3'd4:    rd_data = oam_data_in;
      3'd7:    rd_data = buffer;
      default: rd_data = 8'h00;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      w             <= 1'b0;
      t             <= '0;
      v             <= '0;
      buffer        <= 8'h00;
      vblank_flag   <= 1'b0;
      vram_we_q     <= 1'b0;
      oam_we_q      <= 1'b0;
      vram_data_out <= 8'h00;
      oam_addr      <= '0;
      oam_data_out  <= 8'h00;
      ctrl          <= 8'h00;
      mask          <= 8'h00;
      scroll_x      <= 8'h00;
      scroll_y      <= 8'h00;
      nmi           <= 1'b0;
      bus.data_out  <= 8'h00;
      bus.busy      <= 1'b0;
    end else begin
      vram_we_q   <= 1'b0;
      vblank_flag <= flag_next;
      nmi         <= vblank_flag & ctrl[7];

      // OAM address advances the cycle after the OAMDATA write strobe.
      if (oam_we_q) begin
        oam_we_q <= 1'b0;
        oam_addr <= oam_addr + OAM_W'(1);
      end

      case (state)
        RD_FETCH: begin
          buffer   <= vram_data_in;
          v        <= v + inc;
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        WR_STROBE: begin
          v        <= v + inc;
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        IDLE: begin
          if (wr) begin
            case (bus.ppu_reg_addr)
              3'd0: begin
                ctrl      <= bus.data_in;
                t[11:10]  <= bus.data_in[1:0];
              end
              3'd1: mask <= bus.data_in;
              3'd3: oam_addr <= OAM_W'(bus.data_in);
              3'd4: begin
                oam_we_q     <= 1'b1;
                oam_data_out <= bus.data_in;
              end
              3'd5: begin
                if (w) scroll_y <= bus.data_in;
                else   scroll_x <= bus.data_in;
                w <= ~w;
              end
              3'd6: begin
                if (w) begin
                  t[7:0] <= bus.data_in;
                  v      <= VADDR_W'({t[13:8], bus.data_in});
                end else begin
                  t[13:8] <= bus.data_in[5:0];
                end
                w <= ~w;
              end
              3'd7: begin
                vram_we_q     <= 1'b1;
                vram_data_out <= bus.data_in;
                state         <= WR_STROBE;
                bus.busy      <= 1'b1;
              end
              default: ;
            endcase
          end else if (rd) begin
            bus.data_out <= rd_data;
            if (bus.ppu_reg_addr == 3'd2)
              w <= 1'b0;
            if (bus.ppu_reg_addr == 3'd7) begin
              state    <= RD_FETCH;
              bus.busy <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_reg_file.sv
// Directed self-checking bench for ppu_reg_file with a synchronous VRAM model.
module tb_ppu_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data_in;
  logic [7:0]  vram_data_out;
  logic        vram_WE;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;
  logic [7:0]  oam_data_out;
  logic        oam_WE;
  logic        vblank_start, vblank_end, sprite0_hit, sprite_ovf;
  logic [7:0]  ctrl, mask, scroll_x, scroll_y;
  logic        nmi;

  int tests  = 0;
  int errors = 0;

  logic [7:0] ram [0:16383];

  ppu_reg_file_if bus ();

  ppu_reg_file #(.VADDR_W(14), .OAM_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .vram_addr(vram_addr), .vram_data_in(vram_data_in),
    .vram_data_out(vram_data_out), .vram_WE(vram_WE),
    .oam_addr(oam_addr), .oam_data_in(oam_data_in),
    .oam_data_out(oam_data_out), .oam_WE(oam_WE),
    .vblank_start(vblank_start), .vblank_end(vblank_end),
    .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
    .ctrl(ctrl), .mask(mask), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .nmi(nmi)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM, one cycle read latency; contents start as addr[7:0]^5A.
  always @(posedge clk) begin
    if (vram_WE) ram[vram_addr] <= vram_data_out;
    vram_data_in <= ram[vram_addr];
  end

  task automatic access(input logic [2:0] a, input logic we, input logic [7:0] d);
    @(negedge clk);
    bus.ppu_reg_cs = 1'b1; bus.ppu_reg_addr = a; bus.WE = we; bus.data_in = d;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b0; bus.WE = 1'b0;
  endtask

  task automatic pulse_vb(input logic s, input logic e);
    @(negedge clk);
    vblank_start = s; vblank_end = e;
    @(negedge clk);
    vblank_start = 1'b0; vblank_end = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", ctrl); end
    tests++; if (mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", mask); end
    tests++; if (vram_addr !== 14'h0000) begin errors++; $display("FAIL reset_vaddr got %h want 0000", vram_addr); end
    tests++; if (nmi !== 1'b0) begin errors++; $display("FAIL reset_nmi got %b want 0", nmi); end
    tests++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (vram_WE !== 1'b0 || oam_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b%b want 00", vram_WE, oam_WE); end
    reset = 1'b0;
  endtask

  task automatic test_vram_write;
    access(3'd6, 1'b1, 8'h21);
    access(3'd6, 1'b1, 8'h08);
    tests++; if (vram_addr !== 14'h2108) begin errors++; $display("FAIL addr_load got %h want 2108", vram_addr); end
    access(3'd7, 1'b1, 8'hAB);
    tests++; if (vram_WE !== 1'b1 || vram_addr !== 14'h2108 || vram_data_out !== 8'hAB)
      begin errors++; $display("FAIL vram_strobe got we=%b a=%h d=%h want we=1 a=2108 d=AB", vram_WE, vram_addr, vram_data_out); end
    tests++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", bus.busy); end
    @(negedge clk);
    tests++; if (vram_WE !== 1'b0 || vram_addr !== 14'h2109 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL vram_after got we=%b a=%h busy=%b want we=0 a=2109 busy=0", vram_WE, vram_addr, bus.busy); end
    tests++; if (ram[14'h2108] !== 8'hAB) begin errors++; $display("FAIL vram_content got %h want AB", ram[14'h2108]); end
  endtask

  task automatic test_read_wrap;
    access(3'd0, 1'b1, 8'h04);
    tests++; if (ctrl !== 8'h04) begin errors++; $display("FAIL ctrl_wr got %h want 04", ctrl); end
    access(3'd6, 1'b1, 8'h3F);
    access(3'd6, 1'b1, 8'hFF);
    tests++; if (vram_addr !== 14'h3FFF) begin errors++; $display("FAIL addr_3fff got %h want 3FFF", vram_addr); end
    access(3'd7, 1'b0, 8'h00);
    tests++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rd1_data got %h want 00", bus.data_out); end
    @(negedge clk);
    tests++; if (vram_addr !== 14'h001F) begin errors++; $display("FAIL wrap_addr got %h want 001F", vram_addr); end
    access(3'd7, 1'b0, 8'h00);
    tests++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL rd2_data got %h want A5", bus.data_out); end
    @(negedge clk);
    tests++; if (vram_addr !== 14'h003F) begin errors++; $display("FAIL inc32_addr got %h want 003F", vram_addr); end
    access(3'd7, 1'b0, 8'h00);
    tests++; if (bus.data_out !== 8'h45) begin errors++; $display("FAIL rd3_data got %h want 45", bus.data_out); end
    @(negedge clk);
  endtask

  task automatic test_nmi_status;
    logic [7:0] exp_stat;
    pulse_vb(1'b1, 1'b0);
    access(3'd0, 1'b1, 8'h80);
    tests++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_early got %b want 0", nmi); end
    @(negedge clk);
    tests++; if (nmi !== 1'b1) begin errors++; $display("FAIL nmi_set got %b want 1", nmi); end
    access(3'd5, 1'b1, 8'h11);
    access(3'd2, 1'b0, 8'h00);
`ifdef PPU_OPEN_BUS_EN
    exp_stat = 8'hD1;
`else
    exp_stat = 8'hC0;
`endif
    tests++; if (bus.data_out !== exp_stat) begin errors++; $display("FAIL status_rd got %h want %h", bus.data_out, exp_stat); end
    @(negedge clk);
    tests++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_clear got %b want 0", nmi); end
    access(3'd5, 1'b1, 8'h22);
    tests++; if (scroll_x !== 8'h22 || scroll_y !== 8'h00)
      begin errors++; $display("FAIL w_reset got x=%h y=%h want x=22 y=00", scroll_x, scroll_y); end
  endtask

  task automatic test_status_race;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b1; bus.ppu_reg_addr = 3'd2; bus.WE = 1'b0; vblank_start = 1'b1;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b0; vblank_start = 1'b0;
    tests++; if (bus.data_out[7] !== 1'b0) begin errors++; $display("FAIL race_rd got %b want 0", bus.data_out[7]); end
    @(negedge clk);
    tests++; if (nmi !== 1'b1) begin errors++; $display("FAIL race_flag got nmi=%b want 1", nmi); end
    pulse_vb(1'b0, 1'b1);
    @(negedge clk);
    tests++; if (nmi !== 1'b0) begin errors++; $display("FAIL vbl_end got nmi=%b want 0", nmi); end
    pulse_vb(1'b1, 1'b1);
    @(negedge clk);
    tests++; if (nmi !== 1'b0) begin errors++; $display("FAIL vbl_both got nmi=%b want 0", nmi); end
    access(3'd2, 1'b0, 8'h00);
    tests++; if (bus.data_out[7] !== 1'b0) begin errors++; $display("FAIL vbl_both_rd got %b want 0", bus.data_out[7]); end
  endtask

  task automatic test_back_to_back;
    access(3'd6, 1'b1, 8'h05);
    access(3'd6, 1'b1, 8'h00);
    @(negedge clk);
    bus.ppu_reg_cs = 1'b1; bus.ppu_reg_addr = 3'd7; bus.WE = 1'b1; bus.data_in = 8'h5A;
    @(negedge clk);
    bus.ppu_reg_addr = 3'd0; bus.data_in = 8'h00;
    tests++; if (bus.busy !== 1'b1 || vram_WE !== 1'b1)
      begin errors++; $display("FAIL b2b_busy got busy=%b we=%b want 1 1", bus.busy, vram_WE); end
    @(negedge clk);
    bus.ppu_reg_cs = 1'b0; bus.WE = 1'b0;
    tests++; if (ctrl !== 8'h80) begin errors++; $display("FAIL b2b_drop got ctrl=%h want 80", ctrl); end
    tests++; if (vram_addr !== 14'h0501) begin errors++; $display("FAIL b2b_addr got %h want 0501", vram_addr); end
  endtask

  task automatic test_oam;
    logic [7:0] exp_ob;
    access(3'd1, 1'b1, 8'h1E);
    tests++; if (mask !== 8'h1E) begin errors++; $display("FAIL mask_wr got %h want 1E", mask); end
    access(3'd3, 1'b1, 8'hFF);
    tests++; if (oam_addr !== 8'hFF) begin errors++; $display("FAIL oamaddr got %h want FF", oam_addr); end
    access(3'd4, 1'b1, 8'h77);
    tests++; if (oam_WE !== 1'b1 || oam_data_out !== 8'h77 || oam_addr !== 8'hFF)
      begin errors++; $display("FAIL oam_strobe got we=%b d=%h a=%h want 1 77 FF", oam_WE, oam_data_out, oam_addr); end
    @(negedge clk);
    tests++; if (oam_addr !== 8'h00 || oam_WE !== 1'b0)
      begin errors++; $display("FAIL oam_wrap got a=%h we=%b want 00 0", oam_addr, oam_WE); end
    oam_data_in = 8'h3C;
    access(3'd4, 1'b0, 8'h00);
    tests++; if (bus.data_out !== 8'h3C || oam_addr !== 8'h00)
      begin errors++; $display("FAIL oam_rd got d=%h a=%h want 3C 00", bus.data_out, oam_addr); end
    access(3'd0, 1'b0, 8'h00);
`ifdef PPU_OPEN_BUS_EN
    exp_ob = 8'h3C;
`else
    exp_ob = 8'h00;
`endif
    tests++; if (bus.data_out !== exp_ob || ctrl !== 8'h80)
      begin errors++; $display("FAIL wo_read got d=%h ctrl=%h want %h 80", bus.data_out, ctrl, exp_ob); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b1; bus.ppu_reg_addr = 3'd7; bus.WE = 1'b1; bus.data_in = 8'h99;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b0; bus.WE = 1'b0; reset = 1'b1;
    #1;
    tests++; if (vram_WE !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b want 0", vram_WE); end
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.busy !== 1'b0 || ctrl !== 8'h00 || vram_addr !== 14'h0000)
      begin errors++; $display("FAIL rst_mid_state got busy=%b ctrl=%h a=%h want 0 00 0000", bus.busy, ctrl, vram_addr); end
    tests++; if (ram[14'h0501] !== 8'h5B) begin errors++; $display("FAIL rst_mid_ram got %h want 5B", ram[14'h0501]); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1;
    bus.ppu_reg_cs = 1'b0; bus.ppu_reg_addr = 3'd0; bus.WE = 1'b0; bus.data_in = 8'h00;
    vblank_start = 1'b0; vblank_end = 1'b0;
    sprite0_hit = 1'b1; sprite_ovf = 1'b0;
    oam_data_in = 8'h00;
    test_reset;
    test_vram_write;
    test_read_wrap;
    test_nmi_status;
    test_status_race;
    test_back_to_back;
    test_oam;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
